// File: rtl/uart_pkg.sv
// Shared FSM state type, defaults and the saturating counter helper for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } arb_state_t;

  localparam int UART_DATA_W       = 8;
  localparam int UART_BUSY_TIMEOUT = 4;
  localparam int STAT_W            = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: one-hot winner from two valid bits.
// last_gnt=1 means requester 1 won last, so requester 0 has priority on a tie.
module rr_pick2
  import uart_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two requesters; per-requester stats built with UART_ARB_STATS_EN.
// Ready is combinational in IDLE with tx_trig one cycle later; requesters stall while a frame, gap or busy transmitter is pending.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT
) (
  input  logic              iclk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_trig,
  input  logic              tx_busy,
  output logic [1:0]        grant,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1
);

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam logic [3:0] TO_LAST  = 4'(BUSY_TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_gnt_q, last_gnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [1:0]        pick;

  rr_pick2 u_pick (
    .valid    ({req1_valid, req0_valid}),
    .last_gnt (last_gnt_q),
    .pick     (pick)
  );

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    last_gnt_d = last_gnt_q;
    gap_cnt_d  = gap_cnt_q;
    wait_cnt_d = wait_cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    tx_trig    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d = 2'b00;
        if (!tx_busy && (pick != 2'b00)) begin
          req0_ready = pick[0];
          req1_ready = pick[1];
          tx_data_d  = pick[1] ? req1_data : req0_data;
          grant_d    = pick;
          last_gnt_d = pick[1];
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_trig    = 1'b1;
        wait_cnt_d = 4'd0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wait_cnt_q == TO_LAST) begin
          // Byte is lost; still honour the inter-byte gap so the line settles.
          gap_cnt_d = 8'd0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_cnt_d = 8'd0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // A requester must never see a handshake while the arbiter is being reset.
    if (reset) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  always_ff @(posedge iclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      grant_q    <= 2'b00;
      last_gnt_q <= 1'b1;
      gap_cnt_q  <= 8'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      last_gnt_q <= last_gnt_d;
      gap_cnt_q  <= gap_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign tx_data = tx_data_q;
  assign grant   = grant_q;

`ifdef UART_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic        byte_done;

  // Only bytes that actually went out on the line are counted.
  always_comb begin
    byte_done = (state_q == ST_WAIT_DONE) && !tx_busy;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (byte_done && grant_q[0]) cnt0_d = sat_inc(cnt0_q);
    if (byte_done && grant_q[1]) cnt1_d = sat_inc(cnt1_q);
  end

  always_ff @(posedge iclk) begin
    if (reset) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`else
  assign stat_cnt0 = 16'd0;
  assign stat_cnt1 = 16'd0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, byte width of both requesters and the transmitter data port.
REQ-002 Parameter: GAP_CYCLES, 0, idle cycles inserted after each transmitted byte before the next grant (0..255).
REQ-003 Parameter: BUSY_TIMEOUT, 4, cycles allowed after tx_trig for tx_busy to rise (1..15).
REQ-004 Port: iclk  in  1  clock, all logic on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: req0_valid  in  1  requester 0 has a byte pending.
REQ-007 Port: req0_data  in  DATA_W  requester 0 byte.
REQ-008 Port: req0_ready  out  1  requester 0 byte accepted this cycle.
REQ-009 Port: req1_valid  in  1  requester 1 has a byte pending.
REQ-010 Port: req1_data  in  DATA_W  requester 1 byte.
REQ-011 Port: req1_ready  out  1  requester 1 byte accepted this cycle.
REQ-012 Port: tx_data  out  DATA_W  byte driven to the UART transmitter.
REQ-013 Port: tx_trig  out  1  one-cycle start pulse to the transmitter.
REQ-014 Port: tx_busy  in  1  transmitter is shifting a frame.
REQ-015 Port: grant  out  2  one-hot owner of the current transfer, 2'b00 when idle.
REQ-016 Port: stat_cnt0, stat_cnt1  out  16 each  bytes sent per requester.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
REQ-018 IDLE: if any valid, pick a winner, drive its ready high combinationally that cycle, latch its data into tx_data, set grant, go to LAUNCH; other ready stays 0.
REQ-019 Arbitration: round-robin; with both valid, the requester not granted last wins; after reset, requester 0 has priority.
REQ-020 A requester holds valid and data stable until ready; a transfer occurs only on valid&ready.
REQ-021 LAUNCH: tx_trig=1 for exactly one cycle (cycle N+1 for acceptance in cycle N), then WAIT_BUSY.
REQ-022 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; if tx_busy stays 0 for BUSY_TIMEOUT cycles, the byte is counted lost (not added to stats) and the FSM goes to GAP.
REQ-023 WAIT_DONE: on tx_busy=0 go to GAP, or directly to IDLE if GAP_CYCLES=0; the owning stat counter increments on this exit.
REQ-024 GAP: count GAP_CYCLES cycles, then IDLE; grant returns to 2'b00 on entry to IDLE.
REQ-025 tx_data is held constant from LAUNCH until the next acceptance.
REQ-026 tx_busy already high in IDLE: no acceptance until it falls.
REQ-027 Stat counters saturate at 16'hFFFF.

Reset
REQ-028 While reset=1, on the clock edge: state IDLE, tx_trig 0, tx_data 0, grant 0, both ready 0, counters 0, round-robin pointer to requester 0.
REQ-029 Reset mid-transfer abandons the byte without another tx_trig; the transmitter is reset separately.

Configuration
REQ-030 Macro UART_ARB_STATS_EN: when defined, stat_cnt0/1 count as specified; when undefined, the counters are not built and both ports are tied to 0.

Structure
REQ-031 Package uart_pkg holds the FSM state typedef, the DATA_W default and the BUSY_TIMEOUT default.
REQ-032 Sub-module rr_pick2: combinational two-way round-robin pick from valid bits and last-grant bit.

Verification
REQ-033 Only req0_valid with 8'h0D -> req0_ready 1 cycle, tx_trig next cycle, tx_data=8'h0D, grant=01; tx_busy 1 for 10 cycles -> stat_cnt0=1.
REQ-034 Both valid continuously (8'hA5 and 8'h3C) -> grants alternate 01,10,01,10; tx_data alternates A5,3C.
REQ-035 GAP_CYCLES=3 -> exactly 3 cycles between tx_busy falling and the next ready.
REQ-036 tx_busy never rises -> after BUSY_TIMEOUT=4 cycles FSM leaves WAIT_BUSY; stat counter unchanged; next request served.
REQ-037 reset asserted in WAIT_DONE -> next cycle grant=00, tx_trig=0, counters 0; next request goes to requester 0 when both valid.
REQ-038 Build without UART_ARB_STATS_EN and send 5 bytes -> stat_cnt0=stat_cnt1=0.
